// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Turns debounced cursor-key levels into discrete events (PRESS, LONG,
// REPEAT, RELEASE) delivered through a one-entry valid/ready holding
// register. Only one button is tracked at a time: the lowest-index button
// seen pressed from IDLE. After it is released, every button must go low
// before a new press is recognised.
//
// Build option:
//   BTN_AUTOREPEAT_EN  defined   -> after LONG, REPEAT events every
//                                   REPEAT_CYCLES while the button is held.
//                      undefined -> after LONG, the FSM waits only for the
//                                   release; kind 2'b10 is never produced.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   btn        debounced button levels, 1 = pressed
//   evt_valid  holding register contains an event
//   evt_ready  consumer accepts the event on a clk edge with evt_valid
//   evt_code   index of the button that produced the event
//   evt_kind   00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE
//   evt_ovf    sticky: an event was dropped because the register was full
//   busy       FSM not in IDLE
// ---------------------------------------------------------------------------
module button_event_decoder #(
  parameter int N_BTN         = 5,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CW            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_code,
  output logic [1:0]       evt_kind,
  output logic             evt_ovf,
  output logic             busy
);

  localparam logic [1:0] K_PRESS   = 2'b00;
  localparam logic [1:0] K_LONG    = 2'b01;
  localparam logic [1:0] K_REPEAT  = 2'b10;
  localparam logic [1:0] K_RELEASE = 2'b11;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {WAIT_ALL, IDLE, HELD, REPEAT} state_t;
`else
  typedef enum logic [1:0] {WAIT_ALL, IDLE, HELD, HELD_LONG} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    counter;
  logic [N_BTN-1:0] cur_mask;   // one-hot mask of the tracked button
  logic [2:0]       cur_code;

  logic [N_BTN-1:0] low_mask;
  logic [2:0]       low_code;
  logic             cur_held;
  logic             at_term;
  logic             gen;
  logic [1:0]       gen_kind;
  logic [2:0]       gen_code;
  logic             load;

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    low_mask = btn & (~btn + N_BTN'(1));
    low_code = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn[i]) low_code = 3'(i);
    end

    cur_held = |(btn & cur_mask);
    // Terminal count depends on which hold phase the FSM is in.
    at_term  = (counter == ((state == HELD) ? LONG_LAST : REP_LAST));

    gen      = 1'b0;
    gen_kind = K_PRESS;
    gen_code = cur_code;
    case (state)
      IDLE: begin
        if (|btn) begin
          gen      = 1'b1;
          gen_kind = K_PRESS;
          gen_code = low_code;
        end
      end
      HELD: begin
        // Release wins over a terminal count in the same cycle.
        if (!cur_held) begin
          gen      = 1'b1;
          gen_kind = K_RELEASE;
        end else if (at_term) begin
          gen      = 1'b1;
          gen_kind = K_LONG;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      REPEAT: begin
        if (!cur_held) begin
          gen      = 1'b1;
          gen_kind = K_RELEASE;
        end else if (at_term) begin
          gen      = 1'b1;
          gen_kind = K_REPEAT;
        end
      end
`else
      HELD_LONG: begin
        if (!cur_held) begin
          gen      = 1'b1;
          gen_kind = K_RELEASE;
        end
      end
`endif
      default: ;
    endcase

    // A slot is free when empty or being drained this very edge.
    load = gen && (!evt_valid || evt_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_ALL;
      counter   <= '0;
      cur_mask  <= '0;
      cur_code  <= '0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_kind  <= K_PRESS;
      evt_ovf   <= 1'b0;
      busy      <= 1'b1;
    end else begin
      // Holding register
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= gen_code;
        evt_kind  <= gen_kind;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (gen && !load) evt_ovf <= 1'b1;

      // Control FSM
      case (state)
        WAIT_ALL: begin
          if (btn == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (|btn) begin
            state    <= HELD;
            busy     <= 1'b1;
            cur_mask <= low_mask;
            cur_code <= low_code;
            counter  <= '0;
          end
        end
        HELD: begin
          if (!cur_held) begin
            state <= WAIT_ALL;
          end else if (at_term) begin
            counter <= '0;
`ifdef BTN_AUTOREPEAT_EN
            state   <= REPEAT;
`else
            state   <= HELD_LONG;
`endif
          end else begin
            counter <= counter + CW'(1);
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        REPEAT: begin
          if (!cur_held) begin
            state <= WAIT_ALL;
          end else if (at_term) begin
            counter <= '0;
          end else begin
            counter <= counter + CW'(1);
          end
        end
`else
        HELD_LONG: begin
          if (!cur_held) state <= WAIT_ALL;
        end
`endif
        default: begin
          state <= WAIT_ALL;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for button_event_decoder (LONG_CYCLES=8, REPEAT_CYCLES=4).
// A behavioural model tracks elapsed hold time since the press and derives
// LONG / REPEAT instants arithmetically; outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int N   = 5;
  localparam int LC  = 8;
  localparam int RC  = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
  localparam int EXP_REP = 2;
`else
  localparam bit AUTOREP = 1'b0;
  localparam int EXP_REP = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn;
  logic         evt_valid;
  logic         evt_ready;
  logic [2:0]   evt_code;
  logic [1:0]   evt_kind;
  logic         evt_ovf;
  logic         busy;

  button_event_decoder #(
    .N_BTN(N), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .CW(8)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_kind(evt_kind),
    .evt_ovf(evt_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acc[4];

  // Reference model state
  bit       m_armed;   // all buttons have been seen low since last release/reset
  int       m_cur;     // tracked button, -1 when none
  int       m_n;       // edges elapsed since the press edge
  bit       m_v;
  int       m_code;
  int       m_kind;
  bit       m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_cur = -1; m_n = 0;
    m_v = 0; m_code = 0; m_kind = 0; m_ovf = 0;
  endtask

  function automatic int lowest(input logic [N-1:0] b);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (b[i]) r = i;
    return r;
  endfunction

  task automatic model_edge(input logic [N-1:0] b, input logic r);
    bit g = 0;
    int gk = 0;
    int gc = 0;
    if (!m_armed) begin
      if (b == 0) m_armed = 1;
    end else if (m_cur < 0) begin
      if (b != 0) begin
        m_cur = lowest(b); m_n = 0; g = 1; gk = 0; gc = m_cur;
      end
    end else begin
      gc = m_cur;
      if (!b[m_cur]) begin
        g = 1; gk = 3; m_armed = 0; m_cur = -1;
      end else begin
        m_n++;
        if (m_n == LC) begin
          g = 1; gk = 1;
        end else if (AUTOREP && m_n > LC && ((m_n - LC) % RC) == 0) begin
          g = 1; gk = 2;
        end
      end
    end
    if (g) begin
      if (!m_v || r) begin
        m_v = 1; m_code = gc; m_kind = gk;
      end else begin
        m_ovf = 1;
      end
    end else if (m_v && r) begin
      m_v = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".valid"}, 32'(evt_valid), 32'(m_v));
    chk({ctx, ".code"},  32'(evt_code),  32'(m_code));
    chk({ctx, ".kind"},  32'(evt_kind),  32'(m_kind));
    chk({ctx, ".ovf"},   32'(evt_ovf),   32'(m_ovf));
    chk({ctx, ".busy"},  32'(busy),      32'(!(m_armed && m_cur < 0)));
  endtask

  task automatic step(input string ctx);
    if (evt_valid && evt_ready) acc[evt_kind]++;
    @(posedge clk);
    model_edge(btn, evt_ready);
    #1;
    check_all(ctx);
  endtask

  task automatic steps(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(ctx);
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic pulse_reset(input string ctx);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all(ctx);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    btn = '0;
    evt_ready = 1'b1;
    model_reset();

    // Reset with btn[2] held: no events until released and re-pressed.
    btn = 5'b00100;
    pulse_reset("rst");
    steps(4, "s1_held");
    btn = '0;         steps(2, "s1_rel");
    btn = 5'b00100;   steps(3, "s1_press");
    btn = '0;         steps(3, "s1_release");

    // Two buttons together: lowest wins; other ignored until all low.
    btn = 5'b01010;   steps(3, "s2_both");
    btn = 5'b01000;   steps(3, "s2_drop1");
    btn = '0;         steps(2, "s2_none");
    btn = 5'b01000;   steps(2, "s2_b3");
    btn = '0;         steps(3, "s2_end");

    // Long hold of btn[0] for 20 cycles.
    for (int k = 0; k < 4; k++) acc[k] = 0;
    btn = 5'b00001;   steps(20, "s3_hold");
    btn = '0;         steps(3, "s3_rel");
    chk("s3_n_press",   32'(acc[0]), 32'd1);
    chk("s3_n_long",    32'(acc[1]), 32'd1);
    chk("s3_n_repeat",  32'(acc[2]), 32'(EXP_REP));
    chk("s3_n_release", 32'(acc[3]), 32'd1);

    // Consumer stalled: RELEASE dropped, overflow sticks.
    evt_ready = 1'b0;
    btn = 5'b10000;   steps(3, "s4_press");
    btn = '0;         steps(3, "s4_rel");
    chk("s4_ovf_set", 32'(evt_ovf), 32'd1);
    chk("s4_held_code", 32'(evt_code), 32'd4);
    evt_ready = 1'b1; steps(2, "s4_drain");
    chk("s4_ovf_sticky", 32'(evt_ovf), 32'd1);
    chk("s4_empty", 32'(evt_valid), 32'd0);

    // Accept and load in the same cycle: no drop.
    pulse_reset("s5_rst");
    steps(1, "s5_idle");
    evt_ready = 1'b0;
    btn = 5'b00010;   steps(2, "s5_press");
    evt_ready = 1'b1;
    btn = '0;         steps(1, "s5_swap");
    chk("s5_kind_rel", 32'(evt_kind), 32'd3);
    chk("s5_no_ovf", 32'(evt_ovf), 32'd0);
    steps(2, "s5_end");

    // Reset mid-HELD with an event pending.
    evt_ready = 1'b0;
    btn = 5'b01000;   steps(3, "s6_press");
    pulse_reset("s6_rst");
    chk("s6_valid_clear", 32'(evt_valid), 32'd0);
    evt_ready = 1'b1;
    steps(12, "s6_stillheld");
    btn = '0;         steps(2, "s6_rel");
    btn = 5'b01000;   steps(2, "s6_again");
    btn = '0;         steps(2, "s6_end");

    // Randomised segment.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) btn = N'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      step("rand");
      if (c == 700) pulse_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced, level-valid button lines for the board cursor keys (up/down/left/right/select).
- Converts them into discrete, queued events: press, long-press, auto-repeat and release.
- Sits between the per-button debouncers and the game-control FSM.
- Events go out through a single valid/ready holding register, so the game FSM can accept them at its own pace.

Parameters:
- N_BTN, 5, number of button inputs (1..8).
- LONG_CYCLES, 50000000, cycles a button must stay held after its press event before a LONG event is issued (1 s at 50 MHz).
- REPEAT_CYCLES, 10000000, cycles between consecutive REPEAT events while held after LONG.
- CW, 32, width of the hold/repeat counter; must hold max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- btn  input  N_BTN  debounced button levels, 1 = pressed, synchronous to clk.
- evt_valid  output  1  holding register contains an event.
- evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready on a clk edge.
- evt_code  output  3  index of the button that produced the event.
- evt_kind  output  2  00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE.
- evt_ovf  output  1  sticky: an event was dropped because the holding register was full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - evt_valid=0, evt_code=0, evt_kind=00, evt_ovf=0, busy=1.
  - Counter=0, FSM=WAIT_ALL. A button held through reset never generates PRESS.
- States and transitions:
  - WAIT_ALL: stay until btn==0, then go to IDLE next cycle. busy=1.
  - IDLE: if btn!=0, capture the lowest-index set bit as cur, generate PRESS(cur), counter=0, go to HELD. busy=0 only in IDLE.
  - HELD:
    - If btn[cur]==0: generate RELEASE(cur), go to WAIT_ALL.
    - Else if counter==LONG_CYCLES-1: generate LONG(cur), counter=0, go to REPEAT.
    - Else counter+1.
  - REPEAT:
    - If btn[cur]==0: generate RELEASE(cur), go to WAIT_ALL.
    - Else if counter==REPEAT_CYCLES-1: generate REPEAT(cur), counter=0.
    - Else counter+1.
- Other buttons pressed while cur is held are ignored. After cur is released, nothing is captured until every button is low (WAIT_ALL).
- Latency: an event appears on evt_valid the cycle after the triggering btn edge or counter terminal value, i.e. a registered output.
- Holding register:
  - Depth is one entry.
  - Load when an event is generated and the register is empty, or is being accepted this same cycle (evt_valid && evt_ready). Accept and load in the same cycle gives no bubble and no drop.
  - If an event is generated while evt_valid=1 and evt_ready=0, the new event is dropped, evt_ovf is set, and the held event is unchanged. FSM transitions still occur.
  - evt_code/evt_kind are stable while evt_valid=1 and evt_ready=0.
  - evt_valid clears on accept unless a new event loads in that cycle.
- Simultaneous events: release has priority over the LONG/REPEAT terminal count in the same cycle.
- Arithmetic: counter is unsigned CW-bit and never wraps, because it is reset at each terminal value.
- evt_ovf clears only on reset.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: REPEAT state and REPEAT events as above.
- Undefined:
  - After LONG, the FSM enters HELD_LONG.
  - In HELD_LONG it waits only for release, then issues RELEASE and goes to WAIT_ALL.
  - REPEAT_CYCLES is unused; evt_kind 10 is never produced.

Test Plan:
(All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4, evt_ready=1 unless stated.)
- Reset released with btn=5'b00100 held -> no events. Release btn, press btn[2] -> PRESS code 2, then RELEASE code 2 on release.
- btn=5'b01010 rising together -> PRESS code 1 only. Drop btn[1] while btn[3] stays high -> RELEASE code 1, no PRESS for 3 until all released and btn[3] pressed again.
- Hold btn[0] for 20 cycles -> PRESS at cycle 1, LONG 8 cycles later, REPEAT every 4 cycles (2 REPEATs), RELEASE one cycle after btn falls. Without BTN_AUTOREPEAT_EN -> PRESS, LONG, RELEASE only.
- evt_ready=0, press and release btn[4] -> evt_valid=1 holding PRESS code 4, RELEASE dropped, evt_ovf=1. Raise evt_ready -> one accept, evt_valid=0, evt_ovf stays 1.
- evt_valid=1 with evt_ready=1 in the same cycle a RELEASE is generated -> RELEASE loads, no drop, evt_ovf=0.
- Assert reset mid-HELD with an event pending -> evt_valid=0 immediately (asynchronous). After reset, the still-held button produces nothing until released.
